// File: rtl/wb_pipelined_mem_slave.sv
// Wishbone B4 pipelined slave backed by a word RAM with fixed response latency
// and an optional periodic stall; out-of-range accesses terminate with err.
module wb_pipelined_mem_slave #(
  parameter int g_addr_width   = 32,
  parameter int g_data_width   = 32,
  parameter int g_mem_words    = 256,
  parameter int g_ack_latency  = 1,
  parameter int g_stall_period = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               wb_cyc_i,
  input  logic                               wb_stb_i,
  input  logic                               wb_we_i,
  input  logic [g_data_width/8-1:0]          wb_sel_i,
  input  logic [g_addr_width-1:0]            wb_adr_i,
  input  logic [g_data_width-1:0]            wb_dat_i,
  output logic                               wb_ack_o,
  output logic                               wb_err_o,
  output logic                               wb_rty_o,
  output logic                               wb_stall_o,
  output logic [g_data_width-1:0]            wb_dat_o,
  output logic [$clog2(g_ack_latency+1)-1:0] outstanding_o
);

  localparam int BYTES = g_data_width / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int MW    = $clog2(g_mem_words);
  localparam int OW    = $clog2(g_ack_latency + 1);
  localparam int SW    = (g_stall_period > 1) ? $clog2(g_stall_period) : 1;
  localparam int LAST  = g_ack_latency - 1;
  localparam logic [SW-1:0] STALL_LAST = SW'((g_stall_period > 1) ? g_stall_period - 1 : 0);

  logic [g_data_width-1:0] mem [g_mem_words];

  logic                    accept;
  logic                    in_range;
  logic [MW-1:0]           word_idx;
  logic [SW-1:0]           stall_cnt;
  logic [OW-1:0]           outstanding_q;
  logic [LAST:0]           vld_p;
  logic [LAST:0]           err_p;
  logic [g_data_width-1:0] dat_p [g_ack_latency];

  assign in_range = (wb_adr_i >> (OFF_W + MW)) == '0;
  assign word_idx = wb_adr_i[OFF_W +: MW];
  assign accept   = wb_cyc_i & wb_stb_i & ~wb_stall_o;

  // Stall counter only advances inside a bus cycle and restarts at every new cycle.
  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      stall_cnt <= '0;
    end else if (!wb_cyc_i || g_stall_period == 0) begin
      stall_cnt <= '0;
    end else if (stall_cnt == STALL_LAST) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign wb_stall_o = (g_stall_period != 0) && wb_cyc_i && (stall_cnt == STALL_LAST);

  // Stage p0: RAM access at the accept edge; read-before-write is safe since
  // at most one request is accepted per edge.
  always_ff @(posedge clk_i) begin
    if (accept && in_range && wb_we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wb_sel_i[b]) mem[word_idx][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
      end
    end
    if (accept) begin
      dat_p[0] <= (in_range && !wb_we_i) ? mem[word_idx] : '0;
    end
    for (int i = 1; i < g_ack_latency; i++) begin
      dat_p[i] <= dat_p[i-1];
    end
  end

  // Stages p1..pL-1: response valids shift; dropping cyc aborts everything in flight.
  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      vld_p         <= '0;
      err_p         <= '0;
      outstanding_q <= '0;
    end else if (!wb_cyc_i) begin
      vld_p         <= '0;
      err_p         <= '0;
      outstanding_q <= '0;
    end else begin
      vld_p[0] <= accept;
      err_p[0] <= accept && !in_range;
      for (int i = 1; i < g_ack_latency; i++) begin
        vld_p[i] <= vld_p[i-1];
        err_p[i] <= err_p[i-1];
      end
      if (accept && !vld_p[LAST]) begin
        outstanding_q <= outstanding_q + OW'(1);
      end else if (!accept && vld_p[LAST]) begin
        outstanding_q <= outstanding_q - OW'(1);
      end
    end
  end

  // Output stage: data is forced to zero outside of a normal termination.
  assign wb_ack_o      = vld_p[LAST] & ~err_p[LAST];
  assign wb_err_o      = vld_p[LAST] &  err_p[LAST];
  assign wb_rty_o      = 1'b0;
  assign wb_dat_o      = wb_ack_o ? dat_p[LAST] : '0;
  assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_wb_pipelined_mem_slave.sv
// Bench for wb_pipelined_mem_slave: three configurations share one request bus;
// a per-cycle monitor checks each against a queue fed by a behavioural model.
module tb_wb_pipelined_mem_slave;

  logic        clk_i = 1'b0;
  logic        rst   = 1'b1;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  sel   = '0;
  logic [31:0] adr   = '0;
  logic [31:0] dat_w = '0;

  logic        a0, e0, r0, s0, a1, e1, r1, s1, a2, e2, r2, s2;
  logic [31:0] d0, d1, d2;
  logic [0:0]  o0;
  logic [1:0]  o1, o2;

  always #5 clk_i = ~clk_i;

  wb_pipelined_mem_slave #(.g_ack_latency(1), .g_stall_period(0), .g_mem_words(256)) u_l1 (
    .clk_i(clk_i), .rst_n_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_ack_o(a0), .wb_err_o(e0),
    .wb_rty_o(r0), .wb_stall_o(s0), .wb_dat_o(d0), .outstanding_o(o0));

  wb_pipelined_mem_slave #(.g_ack_latency(3), .g_stall_period(0), .g_mem_words(256)) u_l3 (
    .clk_i(clk_i), .rst_n_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_ack_o(a1), .wb_err_o(e1),
    .wb_rty_o(r1), .wb_stall_o(s1), .wb_dat_o(d1), .outstanding_o(o1));

  wb_pipelined_mem_slave #(.g_ack_latency(2), .g_stall_period(4), .g_mem_words(64)) u_st (
    .clk_i(clk_i), .rst_n_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_ack_o(a2), .wb_err_o(e2),
    .wb_rty_o(r2), .wb_stall_o(s2), .wb_dat_o(d2), .outstanding_o(o2));

  int lat   [3] = '{1, 3, 2};
  int per   [3] = '{0, 0, 4};
  int words [3] = '{256, 256, 64};

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_no  = 0;
  int          run     [3];
  logic [31:0] mmem    [3][256];
  logic [3:0]  known   [3][256];
  int          q_due   [3][16];
  bit          q_err   [3][16];
  bit          q_rd    [3][16];
  logic [31:0] q_dat   [3][16];
  logic [3:0]  q_msk   [3][16];
  int          q_hd    [3];
  int          q_n     [3];
  int          ack_cnt [3];
  int          err_cnt [3];
  int          max_out [3];
  logic [31:0] last_rd [3];
  int          base_a  [3];
  int          base_e  [3];

  function automatic logic f_ack(int i);
    case (i) 0: return a0; 1: return a1; default: return a2; endcase
  endfunction
  function automatic logic f_err(int i);
    case (i) 0: return e0; 1: return e1; default: return e2; endcase
  endfunction
  function automatic logic f_rty(int i);
    case (i) 0: return r0; 1: return r1; default: return r2; endcase
  endfunction
  function automatic logic f_stall(int i);
    case (i) 0: return s0; 1: return s1; default: return s2; endcase
  endfunction
  function automatic logic [31:0] f_dat(int i);
    case (i) 0: return d0; 1: return d1; default: return d2; endcase
  endfunction
  function automatic logic [31:0] f_out(int i);
    case (i) 0: return 32'(o0); 1: return 32'(o1); default: return 32'(o2); endcase
  endfunction
  function automatic logic [31:0] bm(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h",
               name, inst, cyc_no, act, exp);
    end
  endtask

  // Monitor and reference model: one pass per cycle at the falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc_no++;
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          chk("rst_ack", i, 32'(f_ack(i)), 0);
          chk("rst_err", i, 32'(f_err(i)), 0);
          chk("rst_stall", i, 32'(f_stall(i)), 0);
          chk("rst_dat", i, f_dat(i), 0);
          chk("rst_outstanding", i, f_out(i), 0);
          q_n[i] = 0; q_hd[i] = 0; run[i] = 0;
        end else begin
          bit es, acc, inr;
          int slot, w;
          run[i] = cyc ? run[i] + 1 : 0;
          es = (per[i] != 0) && cyc && (run[i] % per[i] == 0);
          chk("stall", i, 32'(f_stall(i)), 32'(es));
          chk("outstanding", i, f_out(i), q_n[i]);
          chk("rty", i, 32'(f_rty(i)), 0);
          if (f_out(i) > max_out[i]) max_out[i] = f_out(i);
          if (f_ack(i)) ack_cnt[i]++;
          if (f_err(i)) err_cnt[i]++;
          if (q_n[i] > 0 && q_due[i][q_hd[i]] == cyc_no) begin
            slot = q_hd[i];
            chk("resp_ack", i, 32'(f_ack(i)), 32'(!q_err[i][slot]));
            chk("resp_err", i, 32'(f_err(i)), 32'(q_err[i][slot]));
            if (!q_err[i][slot] && q_rd[i][slot]) begin
              chk("rd_data", i, f_dat(i) & bm(q_msk[i][slot]),
                  q_dat[i][slot] & bm(q_msk[i][slot]));
              last_rd[i] = f_dat(i);
            end
            q_hd[i] = (q_hd[i] + 1) % 16;
            q_n[i]--;
          end else begin
            chk("no_ack", i, 32'(f_ack(i)), 0);
            chk("no_err", i, 32'(f_err(i)), 0);
          end
          if (!f_ack(i)) chk("dat_idle", i, f_dat(i), 0);
          if (!cyc) begin
            q_n[i] = 0; q_hd[i] = 0;
          end
          acc = cyc && stb && !es;
          if (acc) begin
            inr  = longint'(adr) < longint'(words[i]) * 4;
            w    = inr ? int'(adr >> 2) : 0;
            slot = (q_hd[i] + q_n[i]) % 16;
            q_due[i][slot] = cyc_no + lat[i];
            q_err[i][slot] = !inr;
            q_rd[i][slot]  = !we;
            q_dat[i][slot] = mmem[i][w];
            q_msk[i][slot] = known[i][w];
            q_n[i]++;
            if (inr && we) begin
              for (int b = 0; b < 4; b++) begin
                if (sel[b]) begin
                  mmem[i][w][b*8 +: 8] = dat_w[b*8 +: 8];
                  known[i][w][b]       = 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [3:0] se, input logic [31:0] d);
    @(posedge clk_i);
    #1;
    cyc = c; stb = s; we = w; adr = a; sel = se; dat_w = d;
  endtask
  task automatic req(input logic w, input logic [31:0] a, input logic [3:0] se,
                     input logic [31:0] d);
    drive(1'b1, 1'b1, w, a, se, d);
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic gap();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic mark();
    for (int i = 0; i < 3; i++) begin
      base_a[i] = ack_cnt[i]; base_e[i] = err_cnt[i]; max_out[i] = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      run[i] = 0; q_hd[i] = 0; q_n[i] = 0; ack_cnt[i] = 0; err_cnt[i] = 0;
      max_out[i] = 0; last_rd[i] = '0;
      for (int w = 0; w < 256; w++) known[i][w] = '0;
    end
    repeat (3) @(posedge clk_i);
    #1 rst = 1'b0;

    // Full write then read back.
    gap();
    req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    req(1'b0, 32'h10, 4'hF, '0);
    idle(5); gap();
    for (int i = 0; i < 3; i++) chk("t1_readback", i, last_rd[i], 32'hDEADBEEF);

    // Byte-enable merge.
    req(1'b1, 32'h20, 4'hF, 32'hFFFFFFFF);
    req(1'b1, 32'h20, 4'b0101, 32'h11223344);
    req(1'b0, 32'h20, 4'hF, '0);
    idle(5); gap();
    for (int i = 0; i < 3; i++) chk("t2_sel_merge", i, last_rd[i], 32'hFF22FF44);

    // Eight back-to-back reads.
    mark();
    for (int k = 0; k < 8; k++) req(1'b0, (k % 2 == 0) ? 32'h10 : 32'h20, 4'hF, '0);
    idle(5); gap();
    chk("t3_acks", 1, 32'(ack_cnt[1] - base_a[1]), 8);
    chk("t3_peak_outstanding", 1, 32'(max_out[1]), 3);

    // Strobe held 12 cycles against the periodic stall.
    mark();
    for (int k = 0; k < 12; k++) req(1'b0, 32'h10, 4'hF, '0);
    idle(5); gap();
    chk("t4_stall_acks", 2, 32'(ack_cnt[2] - base_a[2]), 9);
    chk("t4_nostall_acks", 0, 32'(ack_cnt[0] - base_a[0]), 12);

    // Out-of-range accesses.
    mark();
    req(1'b1, 32'h0, 4'hF, 32'h12345678);
    req(1'b0, 32'h400, 4'hF, '0);
    req(1'b1, 32'h400, 4'hF, 32'hAAAAAAAA);
    req(1'b0, 32'h0, 4'hF, '0);
    idle(5); gap();
    for (int i = 0; i < 2; i++) begin
      chk("t5_err_count", i, 32'(err_cnt[i] - base_e[i]), 2);
      chk("t5_ram_untouched", i, last_rd[i], 32'h12345678);
    end

    // Abort with requests in flight.
    mark();
    req(1'b0, 32'h10, 4'hF, '0);
    req(1'b0, 32'h20, 4'hF, '0);
    gap(); gap(); gap(); gap();
    chk("t6_abort_no_ack", 1, 32'(ack_cnt[1] - base_a[1]), 0);

    // Randomised traffic.
    for (int k = 0; k < 800; k++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h400 + ($urandom_range(0, 255) << 2);
      else if (r == 1) a = $urandom | 32'h8000_0000;
      else if (r == 2) a = 32'h100 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      else             a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      drive(1'($urandom_range(0, 24) != 0), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
    end
    idle(5);

    // Asynchronous reset while responses are in flight.
    req(1'b0, 32'h10, 4'hF, '0);
    req(1'b0, 32'h20, 4'hF, '0);
    @(negedge clk_i);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_rst_ack", i, 32'(f_ack(i)), 0);
      chk("async_rst_err", i, 32'(f_err(i)), 0);
      chk("async_rst_stall", i, 32'(f_stall(i)), 0);
      chk("async_rst_dat", i, f_dat(i), 0);
      chk("async_rst_outstanding", i, f_out(i), 0);
    end
    gap(); gap();
    @(posedge clk_i);
    #1 rst = 1'b0;
    idle(4); gap(); gap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
